// File: rtl/data_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_arbiter_if
// Brief    : LSU-side and memory-side valid/ready bundle of the data-memory
//            arbiter. master = arbiter view, slave = LSUs plus memory.
// Revision : 1.0 - initial release
// ============================================================================
interface data_mem_arbiter_if #(
    parameter int NUM_CONSUMERS = 4,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8
);
    logic [NUM_CONSUMERS-1:0]           consumer_read_valid;
    logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address;
    logic [NUM_CONSUMERS-1:0]           consumer_read_ready;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data;
    logic [NUM_CONSUMERS-1:0]           consumer_write_valid;
    logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data;
    logic [NUM_CONSUMERS-1:0]           consumer_write_ready;

    logic                               mem_read_valid;
    logic [ADDR_BITS-1:0]               mem_read_address;
    logic                               mem_read_ready;
    logic [DATA_BITS-1:0]               mem_read_data;
    logic                               mem_write_valid;
    logic [ADDR_BITS-1:0]               mem_write_address;
    logic [DATA_BITS-1:0]               mem_write_data;
    logic                               mem_write_ready;

    modport master (
        input  consumer_read_valid, consumer_read_address,
        input  consumer_write_valid, consumer_write_address, consumer_write_data,
        input  mem_read_ready, mem_read_data, mem_write_ready,
        output consumer_read_ready, consumer_read_data, consumer_write_ready,
        output mem_read_valid, mem_read_address,
        output mem_write_valid, mem_write_address, mem_write_data
    );

    modport slave (
        output consumer_read_valid, consumer_read_address,
        output consumer_write_valid, consumer_write_address, consumer_write_data,
        output mem_read_ready, mem_read_data, mem_write_ready,
        input  consumer_read_ready, consumer_read_data, consumer_write_ready,
        input  mem_read_valid, mem_read_address,
        input  mem_write_valid, mem_write_address, mem_write_data
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_arbiter
// Brief    : Round-robin arbiter sharing one data-memory read/write channel
//            among NUM_CONSUMERS LSUs, one transaction in flight at a time.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_arbiter #(
    parameter int NUM_CONSUMERS = 4,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8
) (
    input  logic                clk,
    input  logic                reset,
    data_mem_arbiter_if.master  bus
);
    localparam int PTR_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [2:0] {
        IDLE           = 3'd0,
        READ_WAITING   = 3'd1,
        WRITE_WAITING  = 3'd2,
        READ_RELAYING  = 3'd3,
        WRITE_RELAYING = 3'd4
    } state_t;

    state_t                             r_state,             w_state_next;
    logic [PTR_BITS-1:0]                r_rr_ptr,            w_rr_ptr_next;
    logic [PTR_BITS-1:0]                r_grant,             w_grant_next;
    logic                               r_mem_read_valid,    w_mem_read_valid_next;
    logic [ADDR_BITS-1:0]               r_mem_read_address,  w_mem_read_address_next;
    logic                               r_mem_write_valid,   w_mem_write_valid_next;
    logic [ADDR_BITS-1:0]               r_mem_write_address, w_mem_write_address_next;
    logic [DATA_BITS-1:0]               r_mem_write_data,    w_mem_write_data_next;
    logic [NUM_CONSUMERS-1:0]           r_read_ready,        w_read_ready_next;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] r_read_data,         w_read_data_next;
    logic [NUM_CONSUMERS-1:0]           r_write_ready,       w_write_ready_next;

    logic [ADDR_BITS-1:0] w_rd_addr [NUM_CONSUMERS];
    logic [ADDR_BITS-1:0] w_wr_addr [NUM_CONSUMERS];
    logic [DATA_BITS-1:0] w_wr_data [NUM_CONSUMERS];
    logic                 w_found;
    logic [PTR_BITS-1:0]  w_sel;
    logic [PTR_BITS-1:0]  w_sel_inc;

    for (genvar i = 0; i < NUM_CONSUMERS; i++) begin : g_slot
        assign w_rd_addr[i] = bus.consumer_read_address[i*ADDR_BITS +: ADDR_BITS];
        assign w_wr_addr[i] = bus.consumer_write_address[i*ADDR_BITS +: ADDR_BITS];
        assign w_wr_data[i] = bus.consumer_write_data[i*DATA_BITS +: DATA_BITS];
    end

    // Round-robin scan: first requester at or after r_rr_ptr, wrapping mod N.
    always_comb begin
        int idx;
        idx     = 0;
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= NUM_CONSUMERS) idx = idx - NUM_CONSUMERS;
            if (!w_found && (bus.consumer_read_valid[idx] || bus.consumer_write_valid[idx])) begin
                w_found = 1'b1;
                w_sel   = PTR_BITS'(idx);
            end
        end
    end

    assign w_sel_inc = (int'(w_sel) == NUM_CONSUMERS - 1) ? '0 : w_sel + 1'b1;

    always_comb begin
        w_state_next             = r_state;
        w_rr_ptr_next            = r_rr_ptr;
        w_grant_next             = r_grant;
        w_mem_read_valid_next    = r_mem_read_valid;
        w_mem_read_address_next  = r_mem_read_address;
        w_mem_write_valid_next   = r_mem_write_valid;
        w_mem_write_address_next = r_mem_write_address;
        w_mem_write_data_next    = r_mem_write_data;
        w_read_ready_next        = r_read_ready;
        w_read_data_next         = r_read_data;
        w_write_ready_next       = r_write_ready;

        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_grant_next  = w_sel;
                    w_rr_ptr_next = w_sel_inc;
                    // A pending read beats a pending write from the same LSU.
                    if (bus.consumer_read_valid[w_sel]) begin
                        w_mem_read_valid_next   = 1'b1;
                        w_mem_read_address_next = w_rd_addr[w_sel];
                        w_state_next            = READ_WAITING;
                    end else begin
                        w_mem_write_valid_next   = 1'b1;
                        w_mem_write_address_next = w_wr_addr[w_sel];
                        w_mem_write_data_next    = w_wr_data[w_sel];
                        w_state_next             = WRITE_WAITING;
                    end
                end
            end
            READ_WAITING: begin
                if (bus.mem_read_ready) begin
                    w_mem_read_valid_next = 1'b0;
                    w_read_data_next[int'(r_grant)*DATA_BITS +: DATA_BITS] = bus.mem_read_data;
                    w_read_ready_next[r_grant] = 1'b1;
                    w_state_next          = READ_RELAYING;
                end
            end
            WRITE_WAITING: begin
                if (bus.mem_write_ready) begin
                    w_mem_write_valid_next      = 1'b0;
                    w_write_ready_next[r_grant] = 1'b1;
                    w_state_next                = WRITE_RELAYING;
                end
            end
            READ_RELAYING: begin
                if (!bus.consumer_read_valid[r_grant]) begin
                    w_read_ready_next[r_grant] = 1'b0;
                    w_state_next               = IDLE;
                end
            end
            WRITE_RELAYING: begin
                if (!bus.consumer_write_valid[r_grant]) begin
                    w_write_ready_next[r_grant] = 1'b0;
                    w_state_next                = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state             <= IDLE;
            r_rr_ptr            <= '0;
            r_grant             <= '0;
            r_mem_read_valid    <= 1'b0;
            r_mem_read_address  <= '0;
            r_mem_write_valid   <= 1'b0;
            r_mem_write_address <= '0;
            r_mem_write_data    <= '0;
            r_read_ready        <= '0;
            r_read_data         <= '0;
            r_write_ready       <= '0;
        end else begin
            r_state             <= w_state_next;
            r_rr_ptr            <= w_rr_ptr_next;
            r_grant             <= w_grant_next;
            r_mem_read_valid    <= w_mem_read_valid_next;
            r_mem_read_address  <= w_mem_read_address_next;
            r_mem_write_valid   <= w_mem_write_valid_next;
            r_mem_write_address <= w_mem_write_address_next;
            r_mem_write_data    <= w_mem_write_data_next;
            r_read_ready        <= w_read_ready_next;
            r_read_data         <= w_read_data_next;
            r_write_ready       <= w_write_ready_next;
        end
    end

    assign bus.mem_read_valid       = r_mem_read_valid;
    assign bus.mem_read_address     = r_mem_read_address;
    assign bus.mem_write_valid      = r_mem_write_valid;
    assign bus.mem_write_address    = r_mem_write_address;
    assign bus.mem_write_data       = r_mem_write_data;
    assign bus.consumer_read_ready  = r_read_ready;
    assign bus.consumer_read_data   = r_read_data;
    assign bus.consumer_write_ready = r_write_ready;
endmodule
`default_nettype wire
